// File: rtl/pulse_burst_arbiter_if.sv
// Request/grant bundle shared by the pulse-burst requesters and the arbiter.
// The slave side is the arbiter; the master side is the requester pool.
interface pulse_burst_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] count;
  logic                  abort;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  out;

  modport master (output req, count, abort, input ack, done, busy, grant_id, out);
  modport slave  (input req, count, abort, output ack, done, busy, grant_id, out);
endinterface

// File: rtl/pulse_burst_arbiter.sv
// Round-robin arbiter that plays one requester's pulse burst at a prescaled rate
// on a single shared output, followed by a silent gap and a one-cycle done.
module pulse_burst_arbiter #(
  parameter int NREQ      = 4,
  parameter int CNT_W     = 8,
  parameter int PRESC_DIV = 50000,
  parameter int GAP_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pulse_burst_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int HW  = CNT_W + 1;
  localparam int PW  = $clog2(PRESC_DIV);
  localparam int GW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   halves_q, halves_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            out_q, out_d;

  logic            tick_s;
  logic            found_s;
  logic [IDW-1:0]  pick_s;
  logic [IDW:0]    idx_s;
  logic [CNT_W-1:0] cnt_sel_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot = NREQ'(1) << idx;
  endfunction

  assign tick_s = (presc_q == PW'(PRESC_DIV - 1));

  // Round-robin pick: first requesting index at or above the pointer, with wrap.
  always_comb begin
    found_s   = 1'b0;
    pick_s    = '0;
    idx_s     = '0;
    cnt_sel_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_q} + (IDW + 1)'(k);
      idx_s = (idx_s >= (IDW + 1)'(NREQ)) ? idx_s - (IDW + 1)'(NREQ) : idx_s;
      if (!found_s && bus.req[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      cnt_sel_s = (pick_s == IDW'(k)) ? bus.count[k*CNT_W +: CNT_W] : cnt_sel_s;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    halves_d = halves_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    ack_d    = '0;
    done_d   = '0;
    busy_d   = busy_q;
    out_d    = out_q;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        if (found_s) begin
          ack_d    = onehot(pick_s);
          busy_d   = 1'b1;
          gid_d    = pick_s;
          ptr_d    = (pick_s == IDW'(NREQ - 1)) ? '0 : pick_s + 1'b1;
          halves_d = {cnt_sel_s, 1'b0};
          // An empty burst still spends one busy cycle before done.
          if (cnt_sel_s == '0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        presc_d = tick_s ? '0 : presc_q + 1'b1;
        if (bus.abort) begin
          out_d   = 1'b0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (halves_q == '0) begin
          if (GAP_TICKS == 0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = onehot(gid_q);
          end else begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_TICKS);
          end
        end else if (tick_s) begin
          out_d    = ~out_q;
          halves_d = halves_q - 1'b1;
        end else begin
          out_d = out_q;
        end
      end
      ST_GAP: begin
        presc_d = tick_s ? '0 : presc_q + 1'b1;
        out_d   = 1'b0;
        if (gap_q == '0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = onehot(gid_q);
        end else if (bus.abort) begin
          gap_d = '0;
        end else if (tick_s) begin
          gap_d = gap_q - 1'b1;
        end else begin
          gap_d = gap_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        out_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        out_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      halves_q <= '0;
      gap_q    <= '0;
      ptr_q    <= '0;
      gid_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      halves_q <= halves_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = gid_q;
  assign bus.out      = out_q;
endmodule

// File: tb/tb_pulse_burst_arbiter.sv
// Bench for pulse_burst_arbiter: directed timing, table-driven bursts, corner
// sequences and a randomized run against a schedule-level reference model.
module tb_pulse_burst_arbiter;
  localparam int NREQ  = 4;
  localparam int CNT_W = 3;
  localparam int P     = 4;
  localparam int G     = 1;

  typedef struct {
    int id;
    int cnt;
    int exp_done_off;
    int exp_rises;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pulse_burst_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  pulse_burst_arbiter #(
    .NREQ(NREQ), .CNT_W(CNT_W), .PRESC_DIV(P), .GAP_TICKS(G)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = NREQ'(1) << i;
  endfunction

  task automatic set_cnt(input int i, input int c);
    bus.count[i*CNT_W +: CNT_W] = CNT_W'(c);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bus.req   = '0;
    bus.abort = 1'b0;
    step();
    step();
    chk("rst_ack", bus.ack, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gid", bus.grant_id, 0);
    chk("rst_out", bus.out, 0);
    reset_n = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int s = 0; s < budget && !ok; s++) begin
      step();
      if (bus.ack !== '0) ok = 1'b1;
    end
  endtask

  vec_t tbl [5];
  int   rr_exp [9];

  // Reference model state for the randomized run.
  int m_ptr, m_owner, m_a, m_c, m_done, m_idle_from;
  logic [NREQ-1:0] granted;

  initial begin
    bit ok;
    int off, rises, busy_bad, idx, last, g, d;
    bit pending;
    logic prev;
    logic [NREQ-1:0] e_ack, e_done;
    logic e_busy, e_out;

    tbl[0] = '{1, 1, 13, 1};
    tbl[1] = '{2, 0, 1, 0};
    tbl[2] = '{3, 7, 61, 7};
    tbl[3] = '{0, 3, 29, 3};
    tbl[4] = '{2, 5, 45, 5};
    rr_exp = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

    bus.count = '0;
    do_reset();

    // Single request: count 2, absolute timing relative to the request cycle.
    bus.req[0] = 1'b1;
    set_cnt(0, 2);
    for (int k = 1; k <= 23; k++) begin
      step();
      bus.req[0] = 1'b0;
      chk("single_ack", bus.ack, (k == 1) ? 4'b0001 : 4'b0000);
      chk("single_out", bus.out, ((k >= 5 && k <= 8) || (k >= 13 && k <= 16)) ? 1 : 0);
      chk("single_busy", bus.busy, (k >= 1 && k <= 21) ? 1 : 0);
      chk("single_done", bus.done, (k == 22) ? 4'b0001 : 4'b0000);
    end

    // Table of single bursts: done offset from ack and rising-edge count.
    for (int t = 0; t < 5; t++) begin
      bus.req[tbl[t].id] = 1'b1;
      set_cnt(tbl[t].id, tbl[t].cnt);
      wait_ack(8, ok);
      chk("tbl_ack_seen", ok, 1);
      chk("tbl_ack_id", bus.ack, oh(tbl[t].id));
      chk("tbl_gid", bus.grant_id, tbl[t].id);
      bus.req[tbl[t].id] = 1'b0;
      set_cnt(tbl[t].id, 5);
      off = 0; rises = 0; busy_bad = 0; prev = bus.out;
      while (bus.done === '0 && off < 200) begin
        if (bus.busy !== 1'b1) busy_bad++;
        step();
        off++;
        if (bus.out === 1'b1 && prev === 1'b0) rises++;
        prev = bus.out;
      end
      chk("tbl_done_id", bus.done, oh(tbl[t].id));
      chk("tbl_done_off", off, tbl[t].exp_done_off);
      chk("tbl_rises", rises, tbl[t].exp_rises);
      chk("tbl_busy_held", busy_bad, 0);
      chk("tbl_busy_at_done", bus.busy, 0);
      step();
    end

    // Abort while out is high.
    bus.req[1] = 1'b1;
    set_cnt(1, 3);
    wait_ack(8, ok);
    chk("abort_ack_seen", ok, 1);
    bus.req[1] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("abort_pre_out", bus.out, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_out", bus.out, 0);
    chk("abort_busy1", bus.busy, 1);
    chk("abort_done_early", bus.done, 0);
    step();
    chk("abort_done", bus.done, oh(1));
    chk("abort_busy0", bus.busy, 0);
    step();
    chk("abort_done_once", bus.done, 0);

    // Reset during the gap, then every requester asks: pointer restarts at 0.
    bus.req[3] = 1'b1;
    set_cnt(3, 2);
    wait_ack(8, ok);
    chk("rstmid_ack_seen", ok, 1);
    bus.req[3] = 1'b0;
    for (int k = 0; k < 18; k++) step();
    chk("rstmid_in_gap_busy", bus.busy, 1);
    chk("rstmid_in_gap_out", bus.out, 0);
    reset_n = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_cnt(i, 1);
    step();
    reset_n = 1'b1;
    chk("rstmid_ack", bus.ack, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_out", bus.out, 0);
    chk("rstmid_gid", bus.grant_id, 0);

    // Round-robin order, dropping requester 1 after the fifth grant.
    idx = 0; last = -1; pending = 1'b0;
    for (int s = 0; s < 600 && idx < 9; s++) begin
      step();
      if (bus.done !== '0) begin
        chk("rr_done_id", bus.done, (last >= 0) ? oh(last) : 0);
        pending = 1'b0;
      end
      if (bus.ack !== '0) begin
        chk("rr_ack", bus.ack, oh(rr_exp[idx]));
        chk("rr_done_before_ack", pending, 0);
        pending = 1'b1;
        last = rr_exp[idx];
        idx++;
        if (idx == 5) bus.req[1] = 1'b0;
      end
    end
    chk("rr_complete", idx, 9);
    bus.req = '0;
    for (int k = 0; k < 20; k++) step();

    // Randomized traffic against the schedule model.
    do_reset();
    m_ptr = 0; m_owner = 0; m_a = -1; m_c = 0; m_done = -1; m_idle_from = 0;
    granted = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) step();
      e_ack = '0; e_done = '0; e_busy = 1'b0; e_out = 1'b0;
      if (m_a >= 0 && n >= m_a) begin
        d      = n - m_a;
        e_ack  = (n == m_a) ? oh(m_owner) : '0;
        e_done = (n == m_done) ? oh(m_owner) : '0;
        e_busy = (n < m_done);
        e_out  = (n < m_done) && ((d / P) % 2 == 1) && ((d / P) <= 2 * m_c - 1);
      end
      chk("rnd_ack", bus.ack, e_ack);
      chk("rnd_done", bus.done, e_done);
      chk("rnd_busy", bus.busy, e_busy);
      chk("rnd_gid", bus.grant_id, m_owner);
      chk("rnd_out", bus.out, e_out);
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i] && $urandom_range(0, 1) == 0) begin
          bus.req[i] = 1'b0;
          granted[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 15) == 0) begin
          bus.req[i] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0)
          set_cnt(i, ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 3)));
      end
      if (n >= m_idle_from && bus.req != '0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        m_owner     = g;
        m_a         = n + 1;
        m_c         = int'(bus.count[g*CNT_W +: CNT_W]);
        m_done      = (m_c == 0) ? m_a + 1 : m_a + (2 * m_c + G) * P + 1;
        m_idle_from = m_done + 1;
        m_ptr       = (g + 1) % NREQ;
        granted[g]  = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
